// File: rtl/lfsr12_pkg.sv
// rtl/lfsr12_pkg.sv - shared definitions for the 12-bit Galois LFSR generator/checker pair
//
// Purpose: step function, sequence constants and checker state encoding,
// shared by the pattern generator and the receive-side checker.
// Ports: none (package).

package lfsr12_pkg;

  localparam int          LFSR12_PERIOD = 4095;
  localparam logic [11:0] LFSR12_SEED   = 12'hFFF;
  localparam logic [11:0] LFSR12_ZERO   = 12'h000;

  typedef enum logic [1:0] {
    SEED,
    SYNC,
    LOCKED
  } lfsr12_state_e;

  // One Galois step, taps 12,6,4,1; the all-zero word is a lock-up state.
  function automatic logic [11:0] lfsr12_step(input logic [11:0] s);
    return {s[0], s[11:7], s[0] ^ s[6], s[5], s[0] ^ s[4], s[3:2], s[0] ^ s[1]};
  endfunction

endpackage

// File: rtl/lfsr12_sat_counter.sv
// rtl/lfsr12_sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: WIDTH-bit counter that sticks at all-ones; clear wins over increment.
// Ports:
//   i_clk    clock, rising edge
//   i_reset  synchronous active-high reset
//   i_clr    synchronous clear to zero
//   i_inc    increment request
//   o_count  current count (registered)

module lfsr12_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/lfsr12_checker.sv
// rtl/lfsr12_checker.sv - self-synchronising checker for the 12-bit LFSR sequence
//
// Purpose: seeds from the received stream, confirms LOCK_COUNT predictions,
// then flywheels on its own prediction and counts mismatches while locked.
// Optional macro LFSR12_PERIOD_CHECK_EN adds a sequence-period monitor.
// Ports:
//   i_clk        clock, rising edge
//   i_reset      synchronous active-high reset
//   i_valid      i_data carries a sequence word this cycle
//   i_data       received 12-bit word
//   i_clr_err    synchronous clear of o_err_count
//   o_locked     checker locked to the sequence
//   o_error      one-cycle pulse for a mismatch received while locked
//   o_err_count  saturating count of locked mismatches
//   o_expected   next word the checker predicts
//   o_period_err (LFSR12_PERIOD_CHECK_EN only) FFF-to-FFF distance not 4095

module lfsr12_checker
  import lfsr12_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [11:0]      i_data,
  input  logic             i_clr_err,
  output logic             o_locked,
  output logic             o_error,
  output logic [ERR_W-1:0] o_err_count,
  output logic [11:0]      o_expected
`ifdef LFSR12_PERIOD_CHECK_EN
  ,
  output logic             o_period_err
`endif
);

  lfsr12_state_e state_q, state_d;
  logic [11:0]   expected_q, expected_d;
  logic [3:0]    match_cnt_q, match_cnt_d;
  logic [3:0]    miss_cnt_q, miss_cnt_d;
  logic          locked_q, locked_d;
  logic          error_q, error_d;
  logic          err_inc;
  logic          data_match;

  assign data_match = (i_data == expected_q);

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    locked_d    = locked_q;
    error_d     = 1'b0;
    err_inc     = 1'b0;

    if (i_valid) begin
      unique case (state_q)
        SEED: begin
          // Zero can never be part of the sequence, so it cannot seed.
          if (i_data != LFSR12_ZERO) begin
            expected_d  = lfsr12_step(i_data);
            match_cnt_d = '0;
            state_d     = SYNC;
          end
        end

        SYNC: begin
          if (data_match) begin
            expected_d  = lfsr12_step(i_data);
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_q == 4'(LOCK_COUNT - 1)) begin
              state_d    = LOCKED;
              locked_d   = 1'b1;
              miss_cnt_d = '0;
            end
          end else if (i_data != LFSR12_ZERO) begin
            expected_d  = lfsr12_step(i_data);
            match_cnt_d = '0;
          end else begin
            state_d = SEED;
          end
        end

        LOCKED: begin
          // Flywheel: the prediction advances on its own so that a corrupt
          // word cannot derail the sequence.
          expected_d = lfsr12_step(expected_q);
          if (data_match) begin
            miss_cnt_d = '0;
          end else begin
            error_d = 1'b1;
            err_inc = 1'b1;
            if (miss_cnt_q == 4'(LOSS_COUNT - 1)) begin
              state_d  = SEED;
              locked_d = 1'b0;
            end else begin
              miss_cnt_d = miss_cnt_q + 4'd1;
            end
          end
        end

        default: begin
          state_d  = SEED;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= SEED;
      expected_q  <= LFSR12_ZERO;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
    end
  end

  lfsr12_sat_counter #(
    .WIDTH(ERR_W)
  ) u_err_cnt (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clr  (i_clr_err),
    .i_inc  (err_inc),
    .o_count(o_err_count)
  );

  assign o_locked   = locked_q;
  assign o_error    = error_q;
  assign o_expected = expected_q;

`ifdef LFSR12_PERIOD_CHECK_EN
  logic [11:0] word_cnt_q, word_cnt_d;
  logic        armed_q, armed_d;
  logic        period_err_q, period_err_d;

  // word_cnt counts locked words since the last FFF; the FFF word itself
  // completes the count, so a clean period reads 4095 inclusive.
  always_comb begin
    word_cnt_d   = word_cnt_q;
    armed_d      = armed_q;
    period_err_d = 1'b0;
    if (state_q != LOCKED) begin
      word_cnt_d = '0;
      armed_d    = 1'b0;
    end else if (i_valid) begin
      if (data_match && (i_data == LFSR12_SEED)) begin
        // The first FFF after lock only opens the measurement window.
        if (armed_q && ((word_cnt_q + 12'd1) != 12'(LFSR12_PERIOD))) begin
          period_err_d = 1'b1;
        end
        word_cnt_d = '0;
        armed_d    = 1'b1;
      end else begin
        word_cnt_d = word_cnt_q + 12'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word_cnt_q   <= '0;
      armed_q      <= 1'b0;
      period_err_q <= 1'b0;
    end else begin
      word_cnt_q   <= word_cnt_d;
      armed_q      <= armed_d;
      period_err_q <= period_err_d;
    end
  end

  assign o_period_err = period_err_q;
`endif

endmodule

// File: tb/tb_lfsr12_checker.sv
// tb/tb_lfsr12_checker.sv - self-checking bench for lfsr12_checker
//
// Purpose: three checker configurations (default, ERR_W=4, LOCK/LOSS=1) share
// one directed stimulus stream and are compared every cycle against a
// behavioural model, plus literal checks on hand-computed values.
// Ports: none (testbench top).

module tb_lfsr12_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [11:0] data;
  logic        clr;

  logic [2:0]  dut_locked;
  logic [2:0]  dut_error;
  logic [11:0] exp_a, exp_b, exp_c;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [15:0] cnt_c;
`ifdef LFSR12_PERIOD_CHECK_EN
  logic [2:0]  dut_perr;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  lfsr12_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(16)) u_a (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_data(data), .i_clr_err(clr),
    .o_locked(dut_locked[0]), .o_error(dut_error[0]), .o_err_count(cnt_a), .o_expected(exp_a)
`ifdef LFSR12_PERIOD_CHECK_EN
    , .o_period_err(dut_perr[0])
`endif
  );

  lfsr12_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(4)) u_b (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_data(data), .i_clr_err(clr),
    .o_locked(dut_locked[1]), .o_error(dut_error[1]), .o_err_count(cnt_b), .o_expected(exp_b)
`ifdef LFSR12_PERIOD_CHECK_EN
    , .o_period_err(dut_perr[1])
`endif
  );

  lfsr12_checker #(.LOCK_COUNT(1), .LOSS_COUNT(1), .ERR_W(16)) u_c (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_data(data), .i_clr_err(clr),
    .o_locked(dut_locked[2]), .o_error(dut_error[2]), .o_err_count(cnt_c), .o_expected(exp_c)
`ifdef LFSR12_PERIOD_CHECK_EN
    , .o_period_err(dut_perr[2])
`endif
  );

  // Galois step written as shift-and-conditional-xor of the tap mask.
  function automatic logic [11:0] nxt(input logic [11:0] s);
    return (s >> 1) ^ (s[0] ? 12'h829 : 12'h000);
  endfunction

  // Model phase: 0 = seeking a seed, 1 = confirming, 2 = locked.
  typedef struct packed {
    int          ph;
    logic [11:0] exp;
    int          hits;
    int          misses;
    bit          locked;
    bit          err;
    int          cnt;
  } mdl_t;

  function automatic mdl_t mstep(input mdl_t m, input int lockc, input int lossc,
                                 input int errw, input logic r, input logic v,
                                 input logic [11:0] d, input logic c);
    mdl_t n;
    int   maxv;
    maxv  = (1 << errw) - 1;
    n     = m;
    n.err = 1'b0;
    if (r) begin
      n = '0;
      return n;
    end
    if (v) begin
      if (m.ph == 0) begin
        if (d != 12'h000) begin
          n.exp  = nxt(d);
          n.hits = 0;
          n.ph   = 1;
        end
      end else if (m.ph == 1) begin
        if (d == m.exp) begin
          n.exp  = nxt(d);
          n.hits = m.hits + 1;
          if (n.hits >= lockc) begin
            n.ph     = 2;
            n.locked = 1'b1;
            n.misses = 0;
          end
        end else if (d != 12'h000) begin
          n.exp  = nxt(d);
          n.hits = 0;
        end else begin
          n.ph = 0;
        end
      end else begin
        n.exp = nxt(m.exp);
        if (d == m.exp) begin
          n.misses = 0;
        end else begin
          n.err    = 1'b1;
          n.cnt    = (m.cnt < maxv) ? m.cnt + 1 : maxv;
          n.misses = m.misses + 1;
          if (n.misses >= lossc) begin
            n.ph     = 0;
            n.locked = 1'b0;
          end
        end
      end
    end
    if (c) n.cnt = 0;
    return n;
  endfunction

  mdl_t m [3];

  always @(posedge clk) begin
    m[0] <= mstep(m[0], 4, 3, 16, rst, valid, data, clr);
    m[1] <= mstep(m[1], 4, 3, 4,  rst, valid, data, clr);
    m[2] <= mstep(m[2], 1, 1, 16, rst, valid, data, clr);
  end

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_locked",   dut_locked[0], m[0].locked);
      chk("a_error",    dut_error[0],  m[0].err);
      chk("a_errcnt",   cnt_a,         m[0].cnt);
      chk("a_expected", exp_a,         m[0].exp);
      chk("b_locked",   dut_locked[1], m[1].locked);
      chk("b_error",    dut_error[1],  m[1].err);
      chk("b_errcnt",   cnt_b,         m[1].cnt);
      chk("b_expected", exp_b,         m[1].exp);
      chk("c_locked",   dut_locked[2], m[2].locked);
      chk("c_error",    dut_error[2],  m[2].err);
      chk("c_errcnt",   cnt_c,         m[2].cnt);
      chk("c_expected", exp_c,         m[2].exp);
    end
  end

  // One word per call; inputs return to idle just after the capturing edge,
  // so literal checks following a call see that word's response.
  task automatic send(input logic [11:0] d, input logic c);
    @(negedge clk);
    valid = 1'b1;
    data  = d;
    clr   = c;
    @(posedge clk);
    #1;
    valid = 1'b0;
    clr   = 1'b0;
  endtask

  logic [11:0] g;

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    data  = 12'h000;
    clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    chk("reset_locked",   dut_locked[0], 0);
    chk("reset_expected", exp_a, 12'h000);
    chk("reset_errcnt",   cnt_a, 0);

    send(12'h000, 1'b0);
    chk("seed_zero_expected", exp_a, 12'h000);

    // Acquire lock on FFF, FD6, 7EB, BDC, 5EE.
    g = 12'hFFF;
    send(g, 1'b0); g = nxt(g);
    chk("exp_after_fff", exp_a, 12'hFD6);
    send(g, 1'b0); g = nxt(g);
    chk("exp_after_fd6", exp_a, 12'h7EB);
    send(g, 1'b0); g = nxt(g);
    chk("exp_after_7eb", exp_a, 12'hBDC);
    send(g, 1'b0); g = nxt(g);
    chk("unlocked_after_4", dut_locked[0], 0);
    send(g, 1'b0); g = nxt(g);
    chk("locked_after_5", dut_locked[0], 1);

    // Single corrupted word: flywheel keeps lock.
    send(g ^ 12'h001, 1'b0); g = nxt(g);
    chk("single_err_pulse", dut_error[0], 1);
    chk("single_err_cnt",   cnt_a, 1);
    chk("single_err_lock",  dut_locked[0], 1);
    send(g, 1'b0); g = nxt(g);
    chk("flywheel_no_err",  dut_error[0], 0);

    // Valid gap holds everything.
    repeat (10) @(posedge clk);
    #1;
    chk("gap_expected", exp_a, g);
    chk("gap_locked",   dut_locked[0], 1);

    // Clear coincident with a counted mismatch.
    send(g ^ 12'h010, 1'b1); g = nxt(g);
    chk("clr_wins_cnt", cnt_a, 0);
    chk("clr_err_pulse", dut_error[0], 1);
    send(g, 1'b0); g = nxt(g);

    // Loss after three consecutive mismatches.
    send(g ^ 12'h005, 1'b0); g = nxt(g);
    send(g ^ 12'h005, 1'b0); g = nxt(g);
    chk("loss_still_locked", dut_locked[0], 1);
    send(g ^ 12'h005, 1'b0); g = nxt(g);
    chk("loss_unlocked", dut_locked[0], 0);
    chk("loss_errcnt",   cnt_a, 3);

    // Relock after five valid words.
    for (int i = 0; i < 5; i++) begin
      send(g, 1'b0); g = nxt(g);
      if (i == 3) chk("relock_after_4", dut_locked[0], 0);
    end
    chk("relock_after_5", dut_locked[0], 1);

    // Saturation: 20 mismatches interleaved with matches.
    for (int i = 0; i < 20; i++) begin
      send(g ^ 12'h100, 1'b0); g = nxt(g);
      send(g, 1'b0); g = nxt(g);
    end
    chk("sat_b_cnt", cnt_b, 15);
    chk("sat_a_cnt", cnt_a, 23);
    chk("sat_locked", dut_locked[0], 1);

    // Reset mid-lock with a valid word present.
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b1;
    data  = g;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    valid = 1'b0;
    chk("midreset_locked",   dut_locked[0], 0);
    chk("midreset_error",    dut_error[0], 0);
    chk("midreset_errcnt",   cnt_a, 0);
    chk("midreset_expected", exp_a, 12'h000);

    // SYNC paths: zero returns to SEED, non-zero mismatch reseeds.
    send(12'hFFF, 1'b0);
    send(12'h000, 1'b0);
    send(12'hFD6, 1'b0);
    chk("reseed_from_seed", exp_a, 12'h7EB);
    send(12'h123, 1'b0);
    chk("reseed_in_sync", exp_a, 12'h8B8);
    chk("sync_no_lock", dut_locked[0], 0);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
